// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel frame sequencer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 48;

endpackage

// File: rtl/sobel_raster_cnt.sv
// Raster-order col/row/linear-address counter; the address is built by
// incrementing, so no multiplier is needed.
module sobel_raster_cnt #(
  parameter int W      = 8,
  parameter int H      = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] COL_END = ADDR_W'(W - 1);
  localparam logic [ADDR_W-1:0] ROW_END = ADDR_W'(H - 1);

  assign last = (col == COL_END) && (row == ROW_END);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      addr <= addr + ADDR_W'(1);
      if (col == COL_END) begin
        col <= '0;
        row <= row + ADDR_W'(1);
      end else begin
        col <= col + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: streams image RAM into the Sobel core and stores results.
// Optional SOBEL_BORDER_ZERO_EN forces results on the frame border to zero.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing image reads in raster order
// DRAIN | all reads issued, collecting remaining results
// DONE  | one-cycle completion pulse
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int ADDR_W    = 12,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int DRAIN_MAX = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  input  logic              core_ready,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic              pix_sof,
  input  logic [PIX_W-1:0]  sob_data,
  input  logic              sob_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] NPIX_C  = CNT_W'(IMG_W * IMG_H);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(DRAIN_MAX);

  state_t            state, state_nxt;
  logic              start_acc, rd_last, wr_acc;
  logic [ADDR_W-1:0] rd_col, rd_row;
  logic [CNT_W-1:0]  wr_cnt;
  logic [TMO_W-1:0]  tmo;
  logic [PIX_W-1:0]  wr_val;

  assign start_acc = (state == IDLE) && start;
  assign wr_acc    = sob_valid && ((state == FETCH) || (state == DRAIN)) && (wr_cnt < NPIX_C);

  sobel_raster_cnt #(.W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)) u_rd_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (start_acc),
    .en   (rd_en),
    .col  (rd_col),
    .row  (rd_row),
    .addr (rd_addr),
    .last (rd_last)
  );

`ifdef SOBEL_BORDER_ZERO_EN
  localparam logic [ADDR_W-1:0] COL_END = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_END = ADDR_W'(IMG_H - 1);
  logic [ADDR_W-1:0] wr_col, wr_row, wr_lin;
  logic              wr_last, wr_border;

  sobel_raster_cnt #(.W(IMG_W), .H(IMG_H), .ADDR_W(ADDR_W)) u_wr_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (start_acc),
    .en   (wr_acc),
    .col  (wr_col),
    .row  (wr_row),
    .addr (wr_lin),
    .last (wr_last)
  );

  assign wr_border = (wr_row == '0) || (wr_row == ROW_END) || (wr_col == '0) || (wr_col == COL_END);
  assign wr_val    = wr_border ? '0 : sob_data;
`else
  assign wr_val = sob_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (rd_en && rd_last) state_nxt = DRAIN;
      DRAIN:   if ((wr_cnt == NPIX_C) || (tmo == TMO_MAX)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == FETCH) && core_ready;
    busy  = (state == FETCH) || (state == DRAIN);
    done  = (state == DONE);
  end

  // pix_out is gated so it reads 0 whenever no pixel is presented
  assign pix_out = pix_valid ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_cnt    <= '0;
      tmo       <= '0;
      err       <= 1'b0;
    end else begin
      pix_valid <= rd_en;
      pix_sof   <= rd_en && (rd_col == '0) && (rd_row == '0);
      wr_en     <= wr_acc;
      if (wr_acc) begin
        wr_addr <= wr_cnt[ADDR_W-1:0];
        wr_data <= wr_val;
        wr_cnt  <= wr_cnt + CNT_W'(1);
      end
      if (start_acc) wr_cnt <= '0;

      if ((state != DRAIN) || sob_valid) tmo <= '0;
      else if (tmo != TMO_MAX)           tmo <= tmo + TMO_W'(1);

      // a full result count on the same cycle as saturation still counts as success
      if (start_acc)
        err <= 1'b0;
      else if ((state == DRAIN) && (tmo == TMO_MAX) && (wr_cnt != NPIX_C))
        err <= 1'b1;
    end
  end

endmodule
